// File: rtl/prime_decode_pkg.sv
// prime_decode_pkg: shared FSM/counter types and the expected-prime table
package prime_decode_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  typedef enum logic [1:0] {CNT_HOLD, CNT_CLR, CNT_LD1, CNT_INC} cnt_op_t;
  localparam int PRIME_TBL_DEPTH = 32;
  localparam logic [7:0] PRIMES [PRIME_TBL_DEPTH] = '{
    8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19,
    8'd23, 8'd29, 8'd31, 8'd37, 8'd41, 8'd43, 8'd47, 8'd53,
    8'd59, 8'd61, 8'd67, 8'd71, 8'd73, 8'd79, 8'd83, 8'd89,
    8'd97, 8'd101, 8'd103, 8'd107, 8'd109, 8'd113, 8'd127, 8'd131
  };
endpackage

// File: rtl/sat_counter.sv
// sat_counter: 32-bit saturating counter with clear/load-1/hold/increment
module sat_counter
  import prime_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  cnt_op_t     op,
  output logic [31:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else q <= op == CNT_CLR ? '0 : op == CNT_LD1 ? 32'd1 : op == CNT_INC && q != '1 ? q + 32'd1 : q;
endmodule

// File: rtl/prime_seq_decoder.sv
// prime_seq_decoder: counts pulse bursts into values, flags sequence end; PRIME_DECODE_CHECK_EN adds prime checking
module prime_seq_decoder
  import prime_decode_pkg::*;
#(
  parameter logic [31:0] PULSE_MIN     = 32'h003D_0900,
  parameter logic [31:0] PRIME_GAP_MIN = 32'h00B7_1B00,
  parameter logic [31:0] SEQ_GAP_MIN   = 32'h016E_3600,
  parameter int          VAL_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prime_seq,
  output logic [VAL_WIDTH-1:0] prime_val,
  output logic                 prime_valid,
  output logic [31:0]          prime_idx,
  output logic                 seq_end,
  output logic                 prime_err
);
  logic s_q;
  state_t state, state_d;
  cnt_op_t hi_op, lo_op;
  logic [31:0] hi_cnt, lo_cnt;
  logic [VAL_WIDTH-1:0] pulse_cnt, pulse_d;
  logic accept, gap_hit, seq_hit;
  sat_counter u_hi (.clk(clk), .rst(rst), .op(hi_op), .q(hi_cnt));
  sat_counter u_lo (.clk(clk), .rst(rst), .op(lo_op), .q(lo_cnt));
  assign accept  = hi_cnt >= PULSE_MIN;
  assign gap_hit = state == LOW && lo_cnt == PRIME_GAP_MIN && pulse_cnt != '0;
  assign seq_hit = state == LOW && lo_cnt == SEQ_GAP_MIN;
  always_comb begin
    state_d = state;
    hi_op   = CNT_HOLD;
    lo_op   = CNT_HOLD;
    pulse_d = pulse_cnt;
    case (state)
      IDLE: begin
        lo_op   = CNT_CLR;
        pulse_d = '0;
        state_d = s_q ? HIGH : IDLE;
        hi_op   = s_q ? CNT_LD1 : CNT_HOLD;
      end
      HIGH: begin
        hi_op   = s_q ? CNT_INC : CNT_HOLD;
        state_d = s_q ? HIGH : LOW;
        lo_op   = s_q ? CNT_HOLD : accept ? CNT_LD1 : CNT_INC;
        pulse_d = !s_q && accept && pulse_cnt != '1 ? pulse_cnt + VAL_WIDTH'(1) : pulse_cnt;
      end
      LOW: begin
        pulse_d = gap_hit ? '0 : pulse_cnt;
        lo_op   = s_q ? CNT_HOLD : CNT_INC;
        hi_op   = s_q ? CNT_LD1 : CNT_HOLD;
        state_d = seq_hit ? IDLE : s_q ? HIGH : LOW;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      s_q         <= 1'b0;
      state       <= IDLE;
      pulse_cnt   <= '0;
      prime_val   <= '0;
      prime_valid <= 1'b0;
      prime_idx   <= '0;
      seq_end     <= 1'b0;
    end else begin
      s_q         <= prime_seq;
      state       <= state_d;
      pulse_cnt   <= pulse_d;
      prime_valid <= gap_hit;
      seq_end     <= seq_hit;
      prime_val   <= gap_hit ? pulse_cnt : prime_val;
      prime_idx   <= seq_hit ? '0 : gap_hit ? prime_idx + 32'd1 : prime_idx;
    end
`ifdef PRIME_DECODE_CHECK_EN
  always_ff @(posedge clk)
    if (rst) prime_err <= 1'b0;
    else prime_err <= gap_hit && prime_idx < 32'(PRIME_TBL_DEPTH) && pulse_cnt != VAL_WIDTH'(PRIMES[prime_idx[4:0]]);
`else
  assign prime_err = 1'b0;
`endif
endmodule

// File: tb/tb_prime_seq_decoder.sv
// tb_prime_seq_decoder: table, hand-written and random checks of prime_seq_decoder against a run-length model
module tb_prime_seq_decoder;
  localparam int PMIN = 4;
  localparam int PGAP = 20;
  localparam int SGAP = 40;
`ifdef PRIME_DECODE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk, rst, prime_seq;
  logic [7:0] prime_val;
  logic prime_valid, seq_end, prime_err;
  logic [31:0] prime_idx;
  prime_seq_decoder #(
    .PULSE_MIN(32'd4), .PRIME_GAP_MIN(32'd20), .SEQ_GAP_MIN(32'd40), .VAL_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .prime_seq(prime_seq), .prime_val(prime_val),
    .prime_valid(prime_valid), .prime_idx(prime_idx), .seq_end(seq_end), .prime_err(prime_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    bit valid;
    bit seq;
    bit err;
    int val;
    longint idx;
  } snap_t;
  typedef struct {
    int n;
    int hi;
    int lo;
    int tail;
    int val;
    int idx;
    int vat;
    int sat;
    bit err;
  } vec_t;
  int vectors = 0;
  int miscompares = 0;
  snap_t pipe0, pipe1;
  bit m_idle, m_skip;
  int m_hi, m_lows, m_pend, m_val;
  longint m_idx;
  function automatic int nth_prime(input longint k);
    int cnt = 0;
    for (int c = 2; c < 1000; c++) begin
      bit p = 1'b1;
      for (int d = 2; d * d <= c; d++) if (c % d == 0) p = 1'b0;
      if (p) begin
        if (cnt == k) return c;
        cnt++;
      end
    end
    return 0;
  endfunction
  task automatic check(input string name, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_idle = 1'b1; m_skip = 1'b0; m_hi = 0; m_lows = 0; m_pend = 0; m_val = 0; m_idx = 0;
    pipe0 = '{default: 0};
    pipe1 = '{default: 0};
  endtask
  // Lows are counted since the last accepted pulse; rejected highs neither reset nor advance the count.
  task automatic model_gaps(inout snap_t s);
    if (m_lows == PGAP && m_pend != 0) begin
      s.valid = 1'b1;
      s.err = CHK && m_idx < 32 && m_pend != nth_prime(m_idx);
      m_val = m_pend;
      m_idx = (m_idx + 1) % 64'h1_0000_0000;
      m_pend = 0;
    end
    if (m_lows == SGAP) begin
      s.seq = 1'b1;
      m_idx = 0; m_idle = 1'b1; m_skip = 1'b1; m_lows = 0; m_pend = 0;
    end
  endtask
  task automatic model_sample(input bit v, output snap_t s);
    s = '{default: 0};
    if (m_skip) m_skip = 1'b0;
    else if (m_idle) begin
      if (v) begin m_idle = 1'b0; m_hi = 1; m_lows = 0; end
    end else if (m_hi > 0) begin
      if (v) m_hi++;
      else begin
        if (m_hi >= PMIN) begin
          m_pend = m_pend < 255 ? m_pend + 1 : 255;
          m_lows = 1;
        end else m_lows++;
        m_hi = 0;
        model_gaps(s);
      end
    end else if (v) m_hi = 1;
    else begin
      m_lows++;
      model_gaps(s);
    end
    s.val = m_val;
    s.idx = m_idx;
  endtask
  task automatic tick(input bit v, input bit r);
    snap_t e, nx;
    prime_seq = v;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
      e = '{default: 0};
    end else begin
      e = pipe0;
      pipe0 = pipe1;
      model_sample(v, nx);
      pipe1 = nx;
    end
    check("prime_valid", prime_valid, e.valid);
    check("seq_end", seq_end, e.seq);
    check("prime_err", prime_err, e.err);
    check("prime_val", prime_val, e.val);
    check("prime_idx", prime_idx, e.idx);
  endtask
  task automatic burst(input int n, input int hi, input int lo);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) tick(1'b1, 1'b0);
      if (p < n - 1) for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
    end
  endtask
  task automatic tail_run(input int len, output int v_at, output int s_at, output int v_val, output int v_idx, output int e_seen);
    v_at = -1; s_at = -1; v_val = -1; v_idx = -1; e_seen = 0;
    for (int i = 1; i <= len; i++) begin
      tick(1'b0, 1'b0);
      if (prime_valid && v_at < 0) begin v_at = i; v_val = int'(prime_val); v_idx = int'(prime_idx); end
      if (seq_end && s_at < 0) s_at = i;
      if (prime_err) e_seen = 1;
    end
  endtask
  task automatic expect_tail(input string name, input vec_t t);
    int v_at, s_at, v_val, v_idx, e_seen;
    tail_run(t.tail, v_at, s_at, v_val, v_idx, e_seen);
    check({name, "_valid_at"}, v_at, t.vat);
    if (t.vat >= 0) begin
      check({name, "_val"}, v_val, t.val);
      check({name, "_idx"}, v_idx, t.idx);
    end
    check({name, "_seq_at"}, s_at, t.sat);
    check({name, "_err"}, e_seen, t.err);
    if (t.sat >= 0) check({name, "_idx_after_seq"}, prime_idx, 0);
  endtask
  vec_t tbl [8];
  initial begin
    prime_seq = 1'b0;
    rst = 1'b1;
    model_reset();
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("reset_val", prime_val, 0);
    check("reset_idx", prime_idx, 0);
    check("reset_strobes", {prime_valid, seq_end, prime_err}, 0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    tbl[0] = '{2, 8, 8, 30, 2, 1, 22, -1, 1'b0};
    tbl[1] = '{3, 8, 8, 30, 3, 2, 22, -1, 1'b0};
    tbl[2] = '{5, 8, 8, 80, 5, 3, 22, 42, 1'b0};
    tbl[3] = '{1, 8, 8, 80, 1, 1, 22, 42, CHK};
    tbl[4] = '{1, 4, 8, 80, 1, 1, 22, 42, CHK};
    tbl[5] = '{2, 3, 8, 80, -1, -1, -1, 34, 1'b0};
    tbl[6] = '{2, 8, 8, 30, 2, 1, 22, -1, 1'b0};
    tbl[7] = '{4, 8, 8, 80, 4, 2, 22, 42, CHK};
    for (int k = 0; k < 8; k++) begin
      burst(tbl[k].n, tbl[k].hi, tbl[k].lo);
      expect_tail($sformatf("tbl%0d", k), tbl[k]);
    end
    // glitch of two highs inside the first inter-pulse gap
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    burst(2, 8, 8);
    expect_tail("glitch", '{0, 0, 0, 80, 3, 1, 22, 42, CHK});
    // reset in the middle of a burst discards the partial count
    burst(2, 8, 8);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("midrst_idx", prime_idx, 0);
    burst(3, 8, 8);
    expect_tail("midrst", '{0, 0, 0, 80, 3, 1, 22, 42, CHK});
    burst(300, 4, 2);
    expect_tail("sat", '{0, 0, 0, 80, 255, 1, 22, 42, CHK});
    for (int r = 0; r < 250; r++) begin
      int hl, ll;
      hl = $urandom_range(1, 9);
      ll = ($urandom_range(0, 5) == 0) ? $urandom_range(18, 60) : $urandom_range(1, 12);
      for (int i = 0; i < hl; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < ll; i++) tick(1'b0, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
